// File: rtl/ternary_pkg.sv
// Shared defaults, index-width derivation and read-side state encoding
// for the ternary result collector.
package ternary_pkg;

    localparam int OUT_LEN_DEF   = 7;
    localparam int BIT_WIDTH_DEF = 8;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_t;

endpackage

// File: rtl/ternary_argmax_tracker.sv
// Running signed max/index over one frame; ties keep the lowest row.
// Optional ReLU clamp of incoming samples under TERNARY_COLLECT_RELU_EN.
module ternary_argmax_tracker #(
    parameter int BIT_WIDTH = 8,
    parameter int IDX_W     = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_load,
    input  logic                        i_update,
    input  logic [IDX_W-1:0]            i_row,
    input  logic signed [BIT_WIDTH-1:0] i_data,
    output logic signed [BIT_WIDTH-1:0] o_data,
    output logic [IDX_W-1:0]            o_idx_next
);

    logic signed [BIT_WIDTH-1:0] r_max;
    logic [IDX_W-1:0]            r_idx;
    logic                        w_take;

`ifdef TERNARY_COLLECT_RELU_EN
    assign o_data = i_data[BIT_WIDTH-1] ? '0 : i_data;
`else
    assign o_data = i_data;
`endif

    // o_idx_next includes the current sample so a completing frame can latch it directly
    assign w_take     = i_load || (i_update && (o_data > r_max));
    assign o_idx_next = i_load ? '0 : (w_take ? i_row : r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (w_take) begin
            r_max <= o_data;
            r_idx <= o_idx_next;
        end
    end

endmodule

// File: rtl/ternary_result_collector.sv
// Collects per-row multiplier results into a two-bank ping-pong frame buffer
// and streams frames out with argmax. ReLU clamp: define TERNARY_COLLECT_RELU_EN.
module ternary_result_collector
    import ternary_pkg::*;
#(
    parameter int OUT_LEN   = OUT_LEN_DEF,
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int IDX_W     = idx_width(OUT_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [IDX_W-1:0]     in_row,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
    output logic [IDX_W-1:0]     argmax_idx,
    output logic                 frame_drop,
    output logic                 seq_err
);

    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(OUT_LEN - 1);

    logic [BIT_WIDTH-1:0] r_mem [2][DEPTH];
    logic [1:0]           r_full;
    logic [IDX_W-1:0]     r_bank_arg [2];
    logic [IDX_W-1:0]     r_exp_row;
    logic                 r_wr_bank;
    logic                 r_keep;
    rd_state_t            r_rd_state;
    logic                 r_rd_bank;
    logic                 r_out_valid;
    logic [BIT_WIDTH-1:0] r_out_data;
    logic [IDX_W-1:0]     r_out_idx;
    logic                 r_out_last;
    logic [IDX_W-1:0]     r_argmax;
    logic                 r_frame_drop;
    logic                 r_seq_err;

    logic                 w_match, w_restart, w_accept, w_first, w_last;
    logic                 w_keep, w_wr_en, w_fill, w_xfer;
    logic [BIT_WIDTH-1:0] w_store_data;
    logic [IDX_W-1:0]     w_idx_next;
    logic [1:0]           w_fill_mask, w_free_mask, w_full_eff;
    logic                 w_free, w_load, w_load_bank;
    logic [IDX_W-1:0]     w_load_idx;
    logic [BIT_WIDTH-1:0] w_ld_data;
    logic [IDX_W-1:0]     w_ld_arg;

    // Write side: row sequencing and the per-frame keep/drop decision taken at row 0
    assign w_match   = in_valid && (in_row == r_exp_row);
    assign w_restart = in_valid && (in_row == '0) && (r_exp_row != '0);
    assign w_accept  = w_match || w_restart;
    assign w_first   = w_accept && (in_row == '0);
    assign w_last    = w_accept && (in_row == LAST_ROW);
    assign w_keep    = w_first ? !r_full[r_wr_bank] : r_keep;
    assign w_wr_en   = w_accept && w_keep;
    assign w_fill    = w_last && w_keep;
    assign w_xfer    = r_out_valid && out_ready;

    ternary_argmax_tracker #(
        .BIT_WIDTH (BIT_WIDTH),
        .IDX_W     (IDX_W)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_first),
        .i_update   (w_accept && !w_first),
        .i_row      (in_row),
        .i_data     (in_data),
        .o_data     (w_store_data),
        .o_idx_next (w_idx_next)
    );

    assign w_fill_mask = w_fill ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_free_mask = w_free ? (2'b01 << r_rd_bank) : 2'b00;
    assign w_full_eff  = r_full | w_fill_mask;

    always_comb begin
        w_free      = 1'b0;
        w_load      = 1'b0;
        w_load_bank = r_rd_bank;
        w_load_idx  = '0;
        if (r_rd_state == RD_IDLE) begin
            w_load = w_full_eff[r_rd_bank];
        end else if (w_xfer) begin
            if (r_out_last) begin
                w_free      = 1'b1;
                w_load_bank = ~r_rd_bank;
                w_load      = w_full_eff[~r_rd_bank];
            end else begin
                w_load     = 1'b1;
                w_load_idx = r_out_idx + 1'b1;
            end
        end
    end

    // Forward the write happening this cycle so a just-completed frame shows with latency 1
    always_comb begin
        w_ld_data = r_mem[w_load_bank][w_load_idx];
        if (w_wr_en && (r_wr_bank == w_load_bank) && (in_row == w_load_idx))
            w_ld_data = w_store_data;
        w_ld_arg = (w_fill && (r_wr_bank == w_load_bank)) ? w_idx_next : r_bank_arg[w_load_bank];
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_bank][in_row] <= w_store_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full       <= '0;
            r_bank_arg   <= '{default: '0};
            r_exp_row    <= '0;
            r_wr_bank    <= 1'b0;
            r_keep       <= 1'b0;
            r_rd_state   <= RD_IDLE;
            r_rd_bank    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_idx    <= '0;
            r_out_last   <= 1'b0;
            r_argmax     <= '0;
            r_frame_drop <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_exp_row <= w_last ? '0 : in_row + 1'b1;
                if (w_first)
                    r_keep <= w_keep;
            end else if (in_valid) begin
                r_exp_row <= '0;
            end
            r_seq_err    <= in_valid && !w_match;
            r_frame_drop <= w_last && !w_keep;
            if (w_fill) begin
                r_wr_bank             <= ~r_wr_bank;
                r_bank_arg[r_wr_bank] <= w_idx_next;
            end
            r_full <= (r_full & ~w_free_mask) | w_fill_mask;

            if (w_free)
                r_rd_bank <= ~r_rd_bank;
            if (w_load) begin
                r_rd_state  <= RD_DRAIN;
                r_out_valid <= 1'b1;
                r_out_data  <= w_ld_data;
                r_out_idx   <= w_load_idx;
                r_out_last  <= (w_load_idx == LAST_ROW);
                r_argmax    <= w_ld_arg;
            end else if (w_free) begin
                r_rd_state  <= RD_IDLE;
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
                r_out_idx   <= '0;
                r_out_last  <= 1'b0;
                r_argmax    <= '0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_idx    = r_out_idx;
    assign out_last   = r_out_last;
    assign argmax_idx = r_argmax;
    assign frame_drop = r_frame_drop;
    assign seq_err    = r_seq_err;

endmodule

// File: tb/tb_ternary_result_collector.sv
// Scoreboard bench for ternary_result_collector: frame-level reference model
// feeds an expected-element queue that a negedge monitor drains.
module tb_ternary_result_collector;

    localparam int OUT_LEN = 7;
    localparam int BW      = 8;
    localparam int IW      = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_row = '0;
    logic [BW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic [IW-1:0] argmax_idx;
    logic          frame_drop;
    logic          seq_err;

    always #5 clk = ~clk;

    ternary_result_collector #(
        .OUT_LEN   (OUT_LEN),
        .BIT_WIDTH (BW),
        .IDX_W     (IW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_row     (in_row),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .argmax_idx (argmax_idx),
        .frame_drop (frame_drop),
        .seq_err    (seq_err)
    );

    typedef struct {
        int data;
        int idx;
        int last;
        int arg;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pending = 0;
    int   exp_drops = 0, exp_seqs = 0, got_drops = 0, got_seqs = 0;
    int   m_exp_row = 0;
    bit   m_keep = 1'b0;
    int   m_frame[OUT_LEN];
    bit   stalled = 1'b0;
    int   h_data, h_idx, h_last, h_arg;
    bit   rnd_done;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int relu(input int v);
`ifdef TERNARY_COLLECT_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Frame-level model: a frame is kept if fewer than two frames are buffered when its row 0 arrives
    task automatic model_row(input int row, input int data);
        int best;
        exp_t x;
        if (row != m_exp_row) begin
            exp_seqs++;
            if (row != 0) begin
                m_exp_row = 0;
                return;
            end
        end
        if (row == 0)
            m_keep = (pending < 2);
        m_frame[row] = relu(data);
        if (row == OUT_LEN - 1) begin
            m_exp_row = 0;
            if (m_keep) begin
                best = 0;
                for (int i = 1; i < OUT_LEN; i++)
                    if (m_frame[i] > m_frame[best]) best = i;
                for (int i = 0; i < OUT_LEN; i++) begin
                    x.data = m_frame[i] & 255;
                    x.idx  = i;
                    x.last = (i == OUT_LEN - 1) ? 1 : 0;
                    x.arg  = best;
                    exp_q.push_back(x);
                end
                pending++;
            end else begin
                exp_drops++;
            end
        end else begin
            m_exp_row = row + 1;
        end
    endtask

    task automatic send(input int row, input int data);
        in_valid = 1'b1;
        in_row   = row[IW-1:0];
        in_data  = data[BW-1:0];
        model_row(row, data);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int d0, input int d1, input int d2, input int d3,
                              input int d4, input int d5, input int d6);
        send(0, d0); send(1, d1); send(2, d2); send(3, d3);
        send(4, d4); send(5, d5); send(6, d6);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(2);
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (frame_drop) got_drops++;
            if (seq_err)    got_seqs++;
            if (stalled) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), h_data);
                check("hold_idx", int'(out_idx), h_idx);
                check("hold_last", int'(out_last), h_last);
                check("hold_argmax", int'(argmax_idx), h_arg);
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_output: got data %0d idx %0d, expected nothing", out_data, out_idx);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", int'(out_data), e.data);
                        check("out_idx", int'(out_idx), e.idx);
                        check("out_last", int'(out_last), e.last);
                        check("argmax_idx", int'(argmax_idx), e.arg);
                        if (e.last != 0) pending--;
                    end
                end else begin
                    stalled = 1'b1;
                    h_data  = int'(out_data);
                    h_idx   = int'(out_idx);
                    h_last  = int'(out_last);
                    h_arg   = int'(argmax_idx);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected simulation end");
        $fatal(1, "watchdog");
    end

    initial begin
        int bubbles;
        int d;

        idle(2);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_argmax", int'(argmax_idx), 0);
        check("rst_frame_drop", int'(frame_drop), 0);
        check("rst_seq_err", int'(seq_err), 0);
        rst_n = 1'b1;
        idle(2);

        // Directed frame, latency 1 and argmax with a tie at rows 2/3
        out_ready = 1'b1;
        send_frame(5, -3, 12, 12, -128, 7, 0);
        @(negedge clk);
        check("t1_latency_valid", int'(out_valid), 1);
        check("t1_first_data", int'(out_data), relu(5));
`ifdef TERNARY_COLLECT_RELU_EN
        check("t1_argmax", int'(argmax_idx), 2);
`else
        check("t1_argmax", int'(argmax_idx), 2);
`endif
        @(posedge clk);
        #1;
        wait_drain("t1_drain");

        // Three frames with a stalled consumer: third is dropped
        out_ready = 1'b0;
        send_frame(1, 2, 3, 4, 5, 6, 7);
        send_frame(-1, -2, 30, -4, 31, -6, -7);
        send_frame(9, 9, 9, 9, 9, 9, 9);
        check("t2_drop_pulse", int'(frame_drop), 1);
        idle(1);
        check("t2_drop_once", int'(frame_drop), 0);
        check("t2_drop_count", got_drops, 1);
        out_ready = 1'b1;
        bubbles = 0;
        for (int i = 0; i < 2 * OUT_LEN; i++) begin
            @(negedge clk);
            if (!out_valid) bubbles++;
        end
        check("t2_no_bubble", bubbles, 0);
        @(posedge clk);
        #1;
        wait_drain("t2_drain");

        // Skipped row aborts the frame
        send(0, 10); send(1, 11); send(2, 12); send(4, 14);
        check("t3_seq_err", int'(seq_err), 1);
        send_frame(-5, 4, 3, 2, 1, 0, -1);
        wait_drain("t3_drain");

        // Early row 0 restarts the frame
        send(0, 50); send(1, 51); send(0, 20);
        check("t4_seq_err", int'(seq_err), 1);
        send(1, 21); send(2, 22); send(3, 23); send(4, 24); send(5, 25); send(6, 26);
        wait_drain("t4_drain");

        // Toggling ready during a drain
        out_ready = 1'b0;
        send_frame(3, 1, 4, 1, 5, 9, 2);
        for (int i = 0; i < 16; i++) begin
            out_ready = (i % 2 == 0);
            idle(1);
        end
        out_ready = 1'b1;
        wait_drain("t5_drain");

        // All-negative frame
        send_frame(-1, -1, -1, -1, -1, -1, -1);
        @(negedge clk);
        check("t6_data", int'(out_data), relu(-1) & 255);
        check("t6_argmax", int'(argmax_idx), 0);
        @(posedge clk);
        #1;
        wait_drain("t6_drain");

        // Randomized frames, corruptions, gaps and consumer backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    if ($urandom_range(0, 5) == 0) begin
                        for (int r = 0; r < int'($urandom_range(1, 5)); r++)
                            send(r, int'($urandom_range(0, 255)) - 128);
                        send(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
                    end else begin
                        for (int r = 0; r < OUT_LEN; r++) begin
                            send(r, int'($urandom_range(0, 255)) - 128);
                            idle(int'($urandom_range(0, 1)) * int'($urandom_range(0, 1)));
                        end
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("rnd_drain");
        check("rnd_drop_count", got_drops, exp_drops);
        check("rnd_seq_count", got_seqs, exp_seqs);

        // Reset in the middle of a drain
        out_ready = 1'b0;
        send_frame(11, 22, 33, 44, 55, 66, 77);
        out_ready = 1'b1;
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", int'(out_valid), 0);
        check("rst_mid_data", int'(out_data), 0);
        exp_q.delete();
        pending   = 0;
        m_exp_row = 0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_frame(-9, 8, -7, 6, 100, 4, -3);
        wait_drain("t7_drain");

        check("final_drop_count", got_drops, exp_drops);
        check("final_seq_count", got_seqs, exp_seqs);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ternary_result_collector.md
Name: ternary_result_collector

Overview:
- Downstream of the ternary matrix-vector multiplier; consumes its per-row 8-bit signed results, one row per cycle.
- Assembles complete output vectors (frames) of OUT_LEN rows into a two-bank ping-pong buffer and tracks the signed argmax per frame.
- Streams each frame out over a valid/ready interface, so the multiplier never stalls and a slow consumer only drops whole frames.

Parameters:
- OUT_LEN, 7, rows per frame (1..8).
- BIT_WIDTH, 8, result width, two's complement.
- IDX_W, 3, row-index width; must satisfy 2^IDX_W >= OUT_LEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_row/in_data qualified this cycle.
- in_row  in  IDX_W  row index of in_data.
- in_data  in  BIT_WIDTH  signed row result.
- out_valid  out  1  out_data holds a buffered element.
- out_ready  in  1  consumer accepts element.
- out_data  out  BIT_WIDTH  current element.
- out_idx  out  IDX_W  row index of out_data.
- out_last  out  1  out_data is the frame's row OUT_LEN-1.
- argmax_idx  out  IDX_W  argmax of the frame being drained; stable while out_valid.
- frame_drop  out  1  one-cycle pulse: completed frame discarded, both banks full.
- seq_err  out  1  one-cycle pulse: out-of-order row, partial frame discarded.

Behaviour:
- Reset (async assert, sync deassert): both banks empty, wr_bank=0, rd_bank=0, expected row=0, running max cleared; all outputs 0.
- Write side, one state variable exp_row (0..OUT_LEN-1):
  - in_valid with in_row==exp_row stores in_data in bank[wr_bank][in_row] and advances exp_row.
  - Running argmax: row 0 loads max=in_data, idx=0. A later row replaces it only on strictly greater signed value, so ties keep the lowest index.
  - Row OUT_LEN-1 accepted: exp_row wraps to 0. If bank[wr_bank] was free at frame start, mark it full, latch its argmax, toggle wr_bank.
  - in_row==0 while exp_row!=0: pulse seq_err, discard the partial frame, and treat the row as row 0 of a new frame.
  - Any other mismatch, including in_row>=OUT_LEN: pulse seq_err, discard, exp_row=0, sample not stored.
  - in_valid low: no change; gaps between rows are allowed.
- Drop rule:
  - Decided at row 0. If both banks are full, the frame is collected into nothing, and frame_drop pulses in the cycle after its last row is accepted.
  - A bank freed during the frame does not rescue it.
- Read side, states IDLE/DRAIN:
  - IDLE moves to DRAIN when bank[rd_bank] is full. out_valid rises the cycle after the completing write (latency 1 from the last in_valid to out_valid).
  - DRAIN presents bank[rd_bank][rd_idx]. A transfer occurs when out_valid && out_ready, which increments rd_idx.
  - Transfer with out_last: free the bank, toggle rd_bank, rd_idx=0. If the other bank is full, stay in DRAIN with no bubble; else go to IDLE.
  - out_data, out_idx, out_last and argmax_idx are held stable while out_valid && !out_ready.
- Simultaneous bank free (read) and bank fill (write) in one cycle are both honoured. A write never targets the bank being drained.
- Throughput: one element per cycle in and out.
- Reset mid-frame or mid-drain: all data lost, outputs 0 immediately.

Optional Feature:
- TERNARY_COLLECT_RELU_EN
- Defined: negative in_data is stored as 0 before buffering and before the argmax compare. An all-negative frame therefore gives argmax_idx=0.
- Undefined: values are stored raw with a signed compare.

Decomposition:
- Shared package ternary_pkg holds OUT_LEN/BIT_WIDTH defaults, the IDX_W derivation, and the read-state encoding (RD_IDLE, RD_DRAIN).
- One natural sub-module: ternary_argmax_tracker (running signed max/index, tie-lowest, optional ReLU clamp), instantiated once on the write side.

Test Plan:
- Rows 0..6 = {5,-3,12,12,-128,7,0} back-to-back, out_ready=1 -> out_valid the cycle after row 6; outputs 5,-3,12,12,-128,7,0 with out_last on the 7th; argmax_idx=2.
- Three frames back-to-back, out_ready=0 -> frames 1 and 2 buffered; frame_drop pulses once after frame 3's row 6. Raising out_ready then yields frames 1 and 2 with no bubble between them.
- Rows 0,1,2 then row 4 -> seq_err pulse; a following clean 0..6 frame is emitted intact and nothing from the aborted frame appears.
- Rows 0,1,0..6 -> seq_err on the second row 0; the emitted frame is the second 0..6 sequence.
- out_ready toggling 1,0,1,0 during a drain -> each element appears exactly once and out_data is held while stalled.
- With TERNARY_COLLECT_RELU_EN, frame all -1 -> outputs all 0, argmax_idx=0. Without it, outputs all -1 (0xFF), argmax_idx=0.
- Assert rst_n low mid-drain -> out_valid=0 immediately; a new frame after release is emitted normally.
